// File: rtl/cla_chunk_add_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cla_chunk_add_sequencer_if                                               |
// | Operand request / result handshake bundle for the chunked adder.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface cla_chunk_add_sequencer_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );
endinterface
`default_nettype wire

// File: rtl/cla_chunk_add_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cla_chunk_add_sequencer                                                  |
// | WIDTH-bit adder built from one CHUNK-bit CLA slice reused over NCHUNK    |
// | cycles, carry registered between chunks.                                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cla_chunk_add_sequencer #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    cla_chunk_add_sequencer_if.slave  bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [IDXW-1:0]  r_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_busy;
    logic             w_last;

    logic [CHUNK-1:0] w_op_a;
    logic [CHUNK-1:0] w_op_b;
    logic [CHUNK-1:0] w_gen;
    logic [CHUNK-1:0] w_prop;
    logic [CHUNK:0]   w_carry;
    logic [CHUNK-1:0] w_slice_sum;

    assign w_last = (r_idx == IDXW'(NCHUNK - 1));
    assign w_op_a = r_a[r_idx*CHUNK +: CHUNK];
    assign w_op_b = r_b[r_idx*CHUNK +: CHUNK];

    generate
        for (genvar gi = 0; gi < CHUNK; gi++) begin : g_pg
            assign w_gen[gi]       = w_op_a[gi] & w_op_b[gi];
            assign w_prop[gi]      = w_op_a[gi] ^ w_op_b[gi];
            assign w_slice_sum[gi] = w_prop[gi] ^ w_carry[gi];
        end
    endgenerate

    // Each carry is expanded as a flat sum of generate terms gated by
    // propagate runs, so no carry depends on a lower slice carry.
    always_comb begin
        logic c_acc;
        logic p_run;
        w_carry    = '0;
        w_carry[0] = r_carry;
        for (int i = 0; i < CHUNK; i++) begin
            c_acc = w_gen[i];
            p_run = w_prop[i];
            for (int j = i - 1; j >= 0; j--) begin
                c_acc = c_acc | (p_run & w_gen[j]);
                p_run = p_run & w_prop[j];
            end
            w_carry[i+1] = c_acc | (p_run & r_carry);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.in_valid)  w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last)        w_state_nxt = ST_DONE;
            ST_DONE: if (bus.out_ready) w_state_nxt = ST_IDLE;
            default:                    w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            ST_IDLE: w_in_ready  = 1'b1;
            ST_RUN:  w_busy      = 1'b1;
            ST_DONE: begin
                w_out_valid = 1'b1;
                w_busy      = 1'b1;
            end
            default: w_in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_carry <= bus.cin;
                        r_idx   <= '0;
                    end
                end
                ST_RUN: begin
                    r_sum[r_idx*CHUNK +: CHUNK] <= w_slice_sum;
                    r_carry                     <= w_carry[CHUNK];
                    r_idx                       <= r_idx + IDXW'(1);
                    if (w_last) begin
                        r_cout <= w_carry[CHUNK];
                        r_ovf  <= w_carry[CHUNK] ^ w_carry[CHUNK-1];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_cla_chunk_add_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cla_chunk_add_sequencer                                               |
// | Directed and randomized checks of the chunked adder against a + b + cin. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_cla_chunk_add_sequencer;
    localparam int WIDTH  = 64;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cla_chunk_add_sequencer_if #(.WIDTH(WIDTH)) bus();

    cla_chunk_add_sequencer #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int acc_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Entered and left on a negedge with the sequencer idle.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic ci,
                          input int hold, input string tag);
        logic [64:0] full;
        logic [63:0] es;
        logic        ec;
        logic        eo;
        int          lat;
        full = {1'b0, a} + {1'b0, b} + {64'd0, ci};
        es   = full[63:0];
        ec   = full[64];
        eo   = (a[63] == b[63]) && (es[63] != a[63]);

        check({tag, ".idle_ready"}, {63'd0, bus.in_ready}, 64'd1);
        bus.in_valid  = 1'b1;
        bus.a         = a;
        bus.b         = b;
        bus.cin       = ci;
        bus.out_ready = (hold == 0);
        acc_cyc       = cyc;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = {$urandom, $urandom};
        bus.b        = {$urandom, $urandom};
        bus.cin      = 1'($urandom_range(0, 1));
        check({tag, ".busy"}, {63'd0, bus.busy}, 64'd1);

        lat = 0;
        while (!bus.out_valid && lat < 2 * NCHUNK) begin
            check({tag, ".run_ready"}, {63'd0, bus.in_ready}, 64'd0);
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'(NCHUNK));
        check({tag, ".out_valid"}, {63'd0, bus.out_valid}, 64'd1);
        check({tag, ".sum"}, bus.sum, es);
        check({tag, ".cout"}, {63'd0, bus.cout}, {63'd0, ec});
        check({tag, ".ovf"}, {63'd0, bus.ovf}, {63'd0, eo});

        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = ~bus.a;
            bus.b        = {$urandom, $urandom};
            @(posedge clk);
            @(negedge clk);
            check({tag, ".hold_valid"}, {63'd0, bus.out_valid}, 64'd1);
            check({tag, ".hold_ready"}, {63'd0, bus.in_ready}, 64'd0);
            check({tag, ".hold_sum"}, bus.sum, es);
            check({tag, ".hold_flags"}, {62'd0, bus.cout, bus.ovf}, {62'd0, ec, eo});
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, ".exit_ready"}, {63'd0, bus.in_ready}, 64'd1);
        check({tag, ".exit_valid"}, {63'd0, bus.out_valid}, 64'd0);
        check({tag, ".exit_busy"}, {63'd0, bus.busy}, 64'd0);
    endtask

    initial begin
        int first_acc;
        logic [63:0] ra;
        logic [63:0] rb;

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", {63'd0, bus.in_ready}, 64'd1);
        check("rst_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_sum", bus.sum, 64'd0);
        check("rst_flags", {62'd0, bus.cout, bus.ovf}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(64'h1, 64'h0, 1'b0, 0, "basic");

        run_op(64'h1C, 64'h0C, 1'b0, 0, "b2b0");
        first_acc = acc_cyc;
        run_op(64'h02, 64'h10, 1'b0, 0, "b2b1");
        check("b2b_spacing", 64'(acc_cyc - first_acc), 64'(NCHUNK + 2));

        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 0, "ripple");
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 0, "sovf");
        run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 5, "bp");

        // Abort in the third RUN cycle, away from any clock edge.
        bus.in_valid = 1'b1;
        bus.a        = 64'h1234;
        bus.b        = 64'h4321;
        bus.cin      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        #1 rst = 1'b1;
        #1;
        check("abort_valid", {63'd0, bus.out_valid}, 64'd0);
        check("abort_busy", {63'd0, bus.busy}, 64'd0);
        check("abort_sum", bus.sum, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready", {63'd0, bus.in_ready}, 64'd1);
        run_op(64'd5, 64'd7, 1'b0, 0, "post_abort");

        for (int n = 0; n < 40; n++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: ;
                1: begin ra = 64'hFFFF_FFFF_FFFF_FFFF; rb = 64'($urandom_range(0, 3)); end
                2: begin ra[63] = 1'b0; rb[63] = 1'b0; end
                default: rb = ~ra;
            endcase
            run_op(ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
